// File: rtl/sd_fifo_tail_s.sv
// Read side of a split FIFO. It tracks the read pointer against the producer's write pointer,
// issues memory reads, and hands words to the consumer through a 2-entry registered output buffer.
module sd_fifo_tail_s #(
    parameter int depth = 16,
    parameter int width = 8,
    parameter int async = 0,
    parameter int asz   = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [asz:0]     wrptr_head,
    output logic [asz:0]     rdptr_tail,
    output logic [asz-1:0]   rd_addr,
    output logic             rd_en,
    input  logic [width-1:0] rd_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [asz:0]     p_usage
);

    logic [asz:0]     wrptr;
    logic [asz:0]     rdptr_reg;
    logic [asz:0]     rdptr_next;
    logic [asz:0]     rdptr_tail_reg;
    logic [asz:0]     rdptr_tail_next;
    logic             inflight_reg;
    logic [1:0]       buf_cnt_reg;
    logic [1:0]       buf_cnt_next;
    logic [width-1:0] buf_reg  [2];
    logic [width-1:0] buf_next [2];
    logic             empty;
    logic             pop;
    logic [2:0]       occupancy;
    logic [2:0]       capacity;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        if (async != 0) begin : g_gray_in
            for (genvar gi = 0; gi <= asz; gi++) begin : g_bit
                assign wrptr[gi] = ^wrptr_head[asz:gi];
            end
        end else begin : g_bin_in
            assign wrptr = wrptr_head;
        end
    endgenerate

    assign empty     = (rdptr_reg == wrptr);
    assign p_srdy    = (buf_cnt_reg != 2'd0);
    assign pop       = p_srdy & p_drdy;
    assign occupancy = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg};
    assign capacity  = 3'd2 + {2'b00, pop};

    // A read is only issued when its returning word is guaranteed a buffer slot.
    assign rd_en      = reset & ~empty & (occupancy < capacity);
    assign rd_addr    = rdptr_reg[asz-1:0];
    assign rdptr_next = rdptr_reg + {{asz{1'b0}}, rd_en};
    assign p_usage    = wrptr - rdptr_reg;
    assign p_data     = buf_reg[0];
    assign rdptr_tail = rdptr_tail_reg;

    always_comb begin
        rdptr_tail_next = rdptr_next;
        if (async != 0) begin
            rdptr_tail_next = rdptr_next ^ (rdptr_next >> 1);
        end
    end

    // buf_reg[0] is always the oldest word; a pop shifts entry 1 down.
    always_comb begin
        buf_cnt_next = buf_cnt_reg;
        buf_next[0]  = buf_reg[0];
        buf_next[1]  = buf_reg[1];
        case ({inflight_reg, pop})
            2'b10: begin
                if (buf_cnt_reg == 2'd0) begin
                    buf_next[0] = rd_data;
                end else begin
                    buf_next[1] = rd_data;
                end
                buf_cnt_next = buf_cnt_reg + 2'd1;
            end
            2'b01: begin
                buf_next[0]  = buf_reg[1];
                buf_cnt_next = buf_cnt_reg - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_reg == 2'd1) begin
                    buf_next[0] = rd_data;
                end else begin
                    buf_next[0] = buf_reg[1];
                    buf_next[1] = rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdptr_reg      <= '0;
            rdptr_tail_reg <= '0;
            inflight_reg   <= 1'b0;
            buf_cnt_reg    <= 2'd0;
        end else begin
            rdptr_reg      <= rdptr_next;
            rdptr_tail_reg <= rdptr_tail_next;
            inflight_reg   <= rd_en;
            buf_cnt_reg    <= buf_cnt_next;
        end
    end

    // Buffer contents need no reset; buf_cnt_reg alone decides what is valid.
    always_ff @(posedge clk) begin
        buf_reg[0] <= buf_next[0];
        buf_reg[1] <= buf_next[1];
    end

endmodule

// File: tb/tb_sd_fifo_tail_s.sv
// Bench for sd_fifo_tail_s: external memory model, scoreboard queue of expected words,
// and a negedge monitor that follows pointer, usage and output behaviour.
module tb_sd_fifo_tail_s;

    localparam int DEPTH = 16;
    localparam int W     = 8;
    localparam int ASZ   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b0;
    logic [ASZ:0]   wrptr_head;
    logic [ASZ:0]   rdptr_tail;
    logic [ASZ-1:0] rd_addr;
    logic           rd_en;
    logic [W-1:0]   rd_data;
    logic           p_srdy;
    logic           p_drdy = 1'b0;
    logic [W-1:0]   p_data;
    logic [ASZ:0]   p_usage;

    logic [ASZ:0]   wrptr_head_a = '0;
    logic [ASZ:0]   rdptr_tail_a;
    logic [ASZ-1:0] rd_addr_a;
    logic           rd_en_a;
    logic [W-1:0]   rd_data_a;
    logic           p_srdy_a;
    logic           p_drdy_a = 1'b1;
    logic [W-1:0]   p_data_a;
    logic [ASZ:0]   p_usage_a;

    sd_fifo_tail_s #(.depth(DEPTH), .width(W), .async(0)) u_dut (
        .clk(clk), .reset(reset), .wrptr_head(wrptr_head), .rdptr_tail(rdptr_tail),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .p_srdy(p_srdy),
        .p_drdy(p_drdy), .p_data(p_data), .p_usage(p_usage)
    );

    sd_fifo_tail_s #(.depth(DEPTH), .width(W), .async(1)) u_dut_a (
        .clk(clk), .reset(reset), .wrptr_head(wrptr_head_a), .rdptr_tail(rdptr_tail_a),
        .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a), .p_srdy(p_srdy_a),
        .p_drdy(p_drdy_a), .p_data(p_data_a), .p_usage(p_usage_a)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem   [DEPTH];
    logic [W-1:0] mem_a [DEPTH];
    logic [ASZ:0] wp = '0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_q_a [$];

    int           reads_total = 0;
    int           pops_total  = 0;
    int           ret_total   = 0;
    logic         inflight_m  = 1'b0;
    logic [ASZ:0] reads_ptr   = '0;
    logic         prev_stall  = 1'b0;
    logic [W-1:0] prev_data   = '0;
    logic [ASZ:0] prev_tail   = '0;
    logic         saw_wrap    = 1'b0;
    logic         exp_srdy;

    assign wrptr_head = wp;

    function automatic logic [ASZ:0] usage_model();
        logic [ASZ:0] u;
        u = wp - reads_ptr;
        return u;
    endfunction

    // Memory model plus read/pop bookkeeping; pops retire scoreboard entries.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (!reset) begin
            reads_total <= 0;
            pops_total  <= 0;
            ret_total   <= 0;
            inflight_m  <= 1'b0;
            reads_ptr   <= '0;
            exp_q.delete();
        end else begin
            if (rd_en) begin
                reads_total <= reads_total + 1;
                reads_ptr   <= reads_ptr + 1'b1;
            end
            ret_total  <= ret_total + (inflight_m ? 1 : 0);
            inflight_m <= rd_en;
            if (p_srdy && p_drdy) begin
                pops_total <= pops_total + 1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            exp_srdy = ((ret_total - pops_total) > 0);
            checks++;
            if (p_srdy !== exp_srdy) begin
                errors++;
                $display("FAIL mon_srdy: got %b expected %b at %0t", p_srdy, exp_srdy, $time);
            end
            if (p_srdy === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mon_data: got %h expected no word at %0t", p_data, $time);
                end else if (p_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL mon_data: got %h expected %h at %0t", p_data, exp_q[0], $time);
                end
            end
            if (prev_stall) begin
                checks++;
                if (p_data !== prev_data) begin
                    errors++;
                    $display("FAIL mon_hold: got %h expected %h at %0t", p_data, prev_data, $time);
                end
            end
            checks++;
            if (p_usage !== usage_model()) begin
                errors++;
                $display("FAIL mon_usage: got %0d expected %0d at %0t", p_usage, usage_model(), $time);
            end
            checks++;
            if (rdptr_tail !== reads_ptr) begin
                errors++;
                $display("FAIL mon_tail: got %h expected %h at %0t", rdptr_tail, reads_ptr, $time);
            end
            checks++;
            if (rd_en === 1'b1 && usage_model() == '0) begin
                errors++;
                $display("FAIL mon_overread: got rd_en 1 expected 0 (empty) at %0t", $time);
            end
            checks++;
            if ((reads_total - pops_total) > 2) begin
                errors++;
                $display("FAIL mon_outstanding: got %0d expected <=2 at %0t", reads_total - pops_total, $time);
            end
            if (prev_tail == 5'h1F && rdptr_tail == 5'h00) saw_wrap = 1'b1;
            prev_tail  = rdptr_tail;
            prev_stall = p_srdy && !p_drdy;
            prev_data  = p_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        mem[wp[ASZ-1:0]] = d;
        exp_q.push_back(d);
        wp = wp + 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wp = '0;
        p_drdy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (p_srdy !== 1'b0) begin errors++; $display("FAIL reset_srdy: got %b expected 0", p_srdy); end
        checks++;
        if (rdptr_tail !== '0) begin errors++; $display("FAIL reset_tail: got %h expected 00", rdptr_tail); end
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++;
        if (p_usage !== '0) begin errors++; $display("FAIL reset_usage: got %0d expected 0", p_usage); end
        tick();
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        p_drdy = 1'b1;
        tick();
        write_word(8'hA5);
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 4'h0) begin
            errors++; $display("FAIL single_rd: got rd_en %b addr %h expected 1 0", rd_en, rd_addr);
        end
        @(negedge clk);
        checks++;
        if (p_srdy !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", p_srdy); end
        @(negedge clk);
        checks++;
        if (p_srdy !== 1'b1 || p_data !== 8'hA5) begin
            errors++; $display("FAIL single_out: got srdy %b data %h expected 1 a5", p_srdy, p_data);
        end
        checks++;
        if (p_usage !== '0) begin errors++; $display("FAIL single_usage: got %0d expected 0", p_usage); end
        @(negedge clk);
        checks++;
        if (p_srdy !== 1'b0) begin errors++; $display("FAIL single_after: got %b expected 0", p_srdy); end
        $display("test_single done");
    endtask

    task automatic test_fill_drain();
        p_drdy = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) write_word(W'(8'h30 + i));
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (p_usage !== 5'd14) begin errors++; $display("FAIL fill_usage: got %0d expected 14", p_usage); end
        checks++;
        if ((reads_total - pops_total) != 2) begin
            errors++; $display("FAIL fill_reads: got %0d expected 2", reads_total - pops_total);
        end
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL fill_rd_en: got %b expected 0", rd_en); end
        tick();
        p_drdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (p_srdy !== 1'b1) begin errors++; $display("FAIL drain_gap: got srdy %b expected 1 at word %0d", p_srdy, i); end
        end
        @(negedge clk);
        checks++;
        if (p_srdy !== 1'b0) begin errors++; $display("FAIL drain_end: got %b expected 0", p_srdy); end
        $display("test_fill_drain done");
    endtask

    task automatic test_wrap();
        int base;
        int remaining;
        int gaps;
        int cyc;
        logic started;
        base = pops_total;
        remaining = 40;
        gaps = 0;
        cyc = 0;
        started = 1'b0;
        saw_wrap = 1'b0;
        p_drdy = 1'b1;
        while ((pops_total - base) < 40 && cyc < 400) begin
            tick();
            if (remaining > 0 && usage_model() != 5'd16) begin
                write_word(W'($urandom));
                remaining--;
            end
            @(negedge clk);
            if (p_srdy) started = 1'b1;
            else if (started && (pops_total - base) < 40) gaps++;
            cyc++;
        end
        checks++;
        if ((pops_total - base) != 40) begin errors++; $display("FAIL wrap_count: got %0d expected 40", pops_total - base); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL wrap_gaps: got %0d expected 0", gaps); end
        checks++;
        if (!saw_wrap) begin errors++; $display("FAIL wrap_tail: got no 1f->00 expected wrap"); end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        int base;
        int written;
        int cyc;
        base = pops_total;
        written = 0;
        cyc = 0;
        while ((pops_total - base) < 200 && cyc < 5000) begin
            tick();
            p_drdy = 1'($urandom_range(0, 1));
            if (written < 200 && $urandom_range(0, 1) == 1 && usage_model() != 5'd16) begin
                write_word(W'($urandom));
                written++;
            end
            cyc++;
        end
        p_drdy = 1'b1;
        checks++;
        if ((pops_total - base) != 200) begin errors++; $display("FAIL random_count: got %0d expected 200", pops_total - base); end
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL random_left: got %0d expected 0", exp_q.size()); end
        $display("test_random done");
    endtask

    task automatic test_reset_mid();
        p_drdy = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) write_word(W'(8'hC0 + i));
        repeat (4) tick();
        p_drdy = 1'b1;
        tick();
        reset = 1'b0;
        wp = '0;
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b expected 0", rd_en); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (p_srdy !== 1'b0) begin errors++; $display("FAIL rstmid_srdy: got %b expected 0", p_srdy); end
        checks++;
        if (rdptr_tail !== '0) begin errors++; $display("FAIL rstmid_tail: got %h expected 00", rdptr_tail); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (p_srdy !== 1'b0) begin errors++; $display("FAIL rstmid_late: got srdy %b data %h expected 0", p_srdy, p_data); end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_async();
        int got;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_a[i] = W'(8'h50 + i);
            exp_q_a.push_back(W'(8'h50 + i));
        end
        wrptr_head_a = 5'h07;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (p_srdy_a) begin
                checks++;
                if (exp_q_a.size() == 0) begin
                    errors++; $display("FAIL async_data: got %h expected no word", p_data_a);
                end else begin
                    if (p_data_a !== exp_q_a[0]) begin
                        errors++; $display("FAIL async_data: got %h expected %h", p_data_a, exp_q_a[0]);
                    end
                    void'(exp_q_a.pop_front());
                end
                got++;
            end
        end
        checks++;
        if (got != 5) begin errors++; $display("FAIL async_count: got %0d expected 5", got); end
        checks++;
        if (rdptr_tail_a !== 5'h07) begin errors++; $display("FAIL async_tail: got %h expected 07", rdptr_tail_a); end
        checks++;
        if (p_usage_a !== '0) begin errors++; $display("FAIL async_usage: got %0d expected 0", p_usage_a); end
        $display("test_async done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_wrap();
        test_random();
        test_reset_mid();
        test_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_fifo_tail_s.md
SD_FIFO_TAIL_S -- requirements
Module: sd_fifo_tail_s

Interface
REQ-001 SHALL have parameter depth, default 16: FIFO depth in words, power of 2, minimum 4.
REQ-002 SHALL have parameter width, default 8: data word width in bits.
REQ-003 SHALL have parameter async, default 0: 1 means pointers exchanged in Gray code, 0 means binary.
REQ-004 SHALL have parameter asz, default $clog2(depth): address width.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-007 SHALL have port wrptr_head, input, asz+1: producer write pointer; Gray if async=1; already synchronized to clk by the instantiating wrapper.
REQ-008 SHALL have port rdptr_tail, output, asz+1: registered read pointer to the head; Gray if async=1, else binary.
REQ-009 SHALL have port rd_addr, output, asz: memory read address, equal to rdptr[asz-1:0].
REQ-010 SHALL have port rd_en, output, 1: memory read strobe, combinational.
REQ-011 SHALL have port rd_data, input, width: memory read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port p_srdy, output, 1: output word valid.
REQ-013 SHALL have port p_drdy, input, 1: consumer ready.
REQ-014 SHALL have port p_data, output, width: output word.
REQ-015 SHALL have port p_usage, output, asz+1: count of words resident in memory and not yet read.

Function
REQ-016 Internal pointers SHALL be binary; wrptr = grey2bin(wrptr_head) when async=1, else wrptr_head.
REQ-017 Empty SHALL be asserted when rdptr == wrptr across all asz+1 bits.
REQ-018 Inflight SHALL be a register equal to the previous cycle's rd_en.
REQ-019 Output buffer SHALL be a 2-entry in-order FIFO (buf_cnt 0..2); pop = p_srdy & p_drdy.
REQ-020 rd_en SHALL equal !empty & (buf_cnt + inflight < 2 + pop); buffer overflow is never permitted.
REQ-021 On rd_en, rdptr SHALL increment by 1 modulo 2*depth; the MSB toggles on address wrap.
REQ-022 rdptr_tail SHALL be registered: bin2grey(next rdptr) when async=1, else next rdptr.
REQ-023 When inflight=1, rd_data SHALL be written into the buffer in that same cycle.
REQ-024 Simultaneous write and pop SHALL leave buf_cnt unchanged and preserve order.
REQ-025 p_srdy SHALL equal (buf_cnt != 0); p_data SHALL be the oldest buffered word, registered with no combinational path from rd_data.
REQ-026 p_data SHALL hold its value while p_srdy=1 and p_drdy=0.
REQ-027 Latency SHALL be 2 cycles: wrptr change seen in cycle N gives rd_en in N and p_srdy in N+2.
REQ-028 Sustained throughput SHALL be 1 word/cycle when p_drdy=1 and the FIFO is non-empty.
REQ-029 p_usage SHALL equal (wrptr - rdptr) mod 2*depth, range 0..depth; buffered and inflight words are excluded.
REQ-030 A full FIFO (p_usage=depth) SHALL be drained normally; when wrptr is unchanged, no read occurs past wrptr.

Reset
REQ-031 While reset=0: rdptr=0, rdptr_tail=0, inflight=0, buf_cnt=0, p_srdy=0.
REQ-032 During reset, rd_en SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard buffered and inflight words; rd_data returning in the following cycle SHALL be ignored.
REQ-034 p_data value during reset SHALL be don't-care.

Verification
REQ-035 depth=16, async=0: wrptr_head 0->1 at cycle 0, mem[0]=0xA5, p_drdy=1 -> rd_en=1 at cycle 0, p_srdy=1 with p_data=0xA5 at cycle 2, p_usage returns to 0.
REQ-036 Load 16 words (wrptr_head=0x10), p_drdy=0 -> exactly 2 reads, p_usage=14, rd_en=0 thereafter; set p_drdy=1 -> 16 words out in order over 16 consecutive cycles.
REQ-037 Wrap test: 40 words streamed through with p_drdy=1 -> rdptr_tail passes 0x1F->0x00, data order intact, no gaps after fill.
REQ-038 Random p_drdy (50%) with 200 random words -> scoreboard matches; buf_cnt never exceeds 2; p_data stable while stalled.
REQ-039 async=1: wrptr_head driven in Gray (bin 5 = 0x07) -> 5 words read; rdptr_tail ends at 0x07.
REQ-040 reset=0 for one cycle with buf_cnt=2 and inflight=1 -> next cycle p_srdy=0, rdptr_tail=0, and the late rd_data is not output.
